// File: rtl/execute_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle_pkg
// Purpose  : Shared encodings for the execute stage. The ALU operation codes
//            are produced by the control unit; the forward selects are
//            produced by the hazard unit.
// Contents : ALU_* opcodes, FWD_* selects, fwd_select() operand mux helper.
// Revision : 1.0 - initial release
// ============================================================================
package execute_cycle_pkg;

  // ALUControl encodings (100, 110 and 111 are unused and yield zero)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Forward-select encodings (11 falls back to the register-file value)
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Operand forwarding mux shared by the A and B paths
  function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                             input logic [31:0] reg_val,
                                             input logic [31:0] wb_val,
                                             input logic [31:0] mem_val);
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_cycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : ALU
// Purpose  : 32-bit combinational ALU for the execute stage.
// Ports    : A, B        - operands
//            ALUControl  - operation select (execute_cycle_pkg ALU_*)
//            Result      - operation result (add/sub wrap modulo 2^32)
//            Zero        - high when Result is zero
// Revision : 1.0 - initial release
// ============================================================================
module ALU
  import execute_cycle_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero
);

  always_comb begin
    Result = 32'h0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {31'b0, ($signed(A) < $signed(B))};
      default: Result = 32'h0;
    endcase
  end

  assign Zero = (Result == 32'h0);

endmodule
`default_nettype wire

// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle
// Purpose  : Execute stage of a 5-stage RISC pipeline plus the EX/MEM
//            register and a saturating taken-redirect counter.
// Ports    : clk, rst (async, active low)
//            ID/EX  : RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE,
//                     ResultSrcE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E,
//                     PCE, PCPlus4E, RD_E
//            Hazard : ForwardAE, ForwardBE, ResultW
//            Redirect (comb) : PCSrcE, PCTargetE
//            EX/MEM (reg)    : RegWriteM, MemWriteM, ResultSrcM, RD_M,
//                              ALUResultM, WriteDataM, PCPlus4M
//            BranchTakenCount - saturating count of redirects
// Revision : 1.0 - initial release
// ============================================================================
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] BranchTakenCount
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  logic        regwrite_q;
  logic        memwrite_q;
  logic [1:0]  resultsrc_q;
  logic [4:0]  rd_q;
  logic [31:0] aluresult_q;
  logic [31:0] writedata_q;
  logic [31:0] pcplus4_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // The MEM-stage forward uses the registered ALU result so a dependent
  // instruction sees the value produced one cycle earlier.
  assign src_a = fwd_select(ForwardAE, RD1_E, ResultW, aluresult_q);
  assign fwd_b = fwd_select(ForwardBE, RD2_E, ResultW, aluresult_q);
  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  ALU u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  // Redirect path is purely combinational and unaffected by reset
  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = (BranchE & alu_zero) | JumpE;

  // Saturating redirect counter
  always_comb begin
    cnt_d = cnt_q;
    if (PCSrcE && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 2'b0;
      rd_q        <= 5'b0;
      aluresult_q <= 32'h0;
      writedata_q <= 32'h0;
      pcplus4_q   <= 32'h0;
      cnt_q       <= 32'h0;
    end else begin
      regwrite_q  <= RegWriteE;
      memwrite_q  <= MemWriteE;
      resultsrc_q <= ResultSrcE;
      rd_q        <= RD_E;
      aluresult_q <= alu_result;
      writedata_q <= fwd_b;       // store data is taken before the ALUSrc mux
      pcplus4_q   <= PCPlus4E;
      cnt_q       <= cnt_d;
    end
  end

  assign RegWriteM        = regwrite_q;
  assign MemWriteM        = memwrite_q;
  assign ResultSrcM       = resultsrc_q;
  assign RD_M             = rd_q;
  assign ALUResultM       = aluresult_q;
  assign WriteDataM       = writedata_q;
  assign PCPlus4M         = pcplus4_q;
  assign BranchTakenCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_cycle
// Purpose  : Self-checking bench for execute_cycle. Expected EX/MEM contents
//            are pushed to a scoreboard queue when an instruction is driven
//            and popped and compared after the capturing clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, BranchTakenCount;

  typedef struct {
    logic        regw;
    logic        memw;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_alu;   // model of the registered ALU result
  logic [31:0] m_cnt;   // model of the redirect counter
  int          n_checks;
  int          n_fail;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .BranchTakenCount(BranchTakenCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_model(input logic [1:0] sel, input logic [31:0] rv,
                                            input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return rv;
  endfunction

  task automatic bubble();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
    ResultSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, ":RegWriteM"}, RegWriteM, 0);
    check({tag, ":MemWriteM"}, MemWriteM, 0);
    check({tag, ":ResultSrcM"}, ResultSrcM, 0);
    check({tag, ":RD_M"}, RD_M, 0);
    check({tag, ":ALUResultM"}, ALUResultM, 0);
    check({tag, ":WriteDataM"}, WriteDataM, 0);
    check({tag, ":PCPlus4M"}, PCPlus4M, 0);
    check({tag, ":count"}, BranchTakenCount, 0);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_step(input string tag);
    logic [31:0] a, bf, b, r;
    logic        taken;
    exp_t        e;
    a     = fwd_model(ForwardAE, RD1_E, ResultW, m_alu);
    bf    = fwd_model(ForwardBE, RD2_E, ResultW, m_alu);
    b     = ALUSrcE ? Imm_Ext_E : bf;
    r     = alu_model(ALUControlE, a, b);
    taken = (BranchE && (r == 32'h0)) || JumpE;
    #1;
    check({tag, ":PCSrcE"}, PCSrcE, taken);
    check({tag, ":PCTargetE"}, PCTargetE, PCE + Imm_Ext_E);
    e.regw = RegWriteE; e.memw = MemWriteE; e.rsrc = ResultSrcE; e.rd = RD_E;
    e.alu  = r; e.wd = bf; e.pc4 = PCPlus4E;
    sb.push_back(e);
    if (taken && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ":RegWriteM"}, RegWriteM, e.regw);
    check({tag, ":MemWriteM"}, MemWriteM, e.memw);
    check({tag, ":ResultSrcM"}, ResultSrcM, e.rsrc);
    check({tag, ":RD_M"}, RD_M, e.rd);
    check({tag, ":ALUResultM"}, ALUResultM, e.alu);
    check({tag, ":WriteDataM"}, WriteDataM, e.wd);
    check({tag, ":PCPlus4M"}, PCPlus4M, e.pc4);
    check({tag, ":count"}, BranchTakenCount, m_cnt);
    m_alu = e.alu;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_alu = 0; m_cnt = 0;
    rst = 1'b0;
    bubble();
    #2;
    check_regs_zero("reset_initial");
    repeat (2) @(negedge clk);
    check_regs_zero("reset_held");
    rst = 1'b1;

    // add 5+7 -> 12, rd=3
    RD1_E = 5; RD2_E = 7; ALUControlE = 3'b000; RegWriteE = 1; RD_E = 3;
    PCPlus4E = 32'h44;
    run_step("add_basic");
    check("add_basic:value", ALUResultM, 32'd12);

    // beq-style sub 9-9 with negative offset
    bubble();
    ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; BranchE = 1;
    PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    check("branch:PCSrcE_direct", PCSrcE, 1);
    check("branch:target_direct", PCTargetE, 32'hF8);
    run_step("branch_taken");
    check("branch:count_direct", BranchTakenCount, 32'd1);

    // Not-taken branch leaves the counter alone
    RD2_E = 8;
    run_step("branch_not_taken");

    // Back-to-back forwarding: 2+3, then MEM(5) + WB(10)
    bubble();
    RD1_E = 2; RD2_E = 3; RegWriteE = 1; RD_E = 5;
    run_step("fwd_first");
    RD1_E = 100; RD2_E = 200; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 10;
    run_step("fwd_second");
    check("fwd_second:value", ALUResultM, 32'd15);

    // Select 11 falls back to the register-file value
    ForwardAE = 2'b11; ForwardBE = 2'b11; RD1_E = 32'h30; RD2_E = 32'h0F; ALUControlE = 3'b011;
    run_step("fwd_11_or");

    // Signed set-less-than both ways
    bubble();
    ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    run_step("slt_neg");
    check("slt_neg:value", ALUResultM, 32'd1);
    RD1_E = 1; RD2_E = 32'hFFFF_FFFF;
    run_step("slt_pos");
    check("slt_pos:value", ALUResultM, 32'd0);

    // Wrap, and/or, and the unused opcodes with branch-on-zero
    bubble();
    ALUControlE = 3'b001; RD1_E = 0; RD2_E = 1;
    run_step("sub_wrap");
    ALUControlE = 3'b000; RD1_E = 32'hFFFF_FFFF; RD2_E = 2;
    run_step("add_wrap");
    ALUControlE = 3'b010; RD1_E = 32'hF0F0_1234; RD2_E = 32'h0FF0_FF00;
    run_step("and");
    for (int k = 0; k < 3; k++) begin
      bubble();
      ALUControlE = (k == 0) ? 3'b100 : ((k == 1) ? 3'b110 : 3'b111);
      RD1_E = 32'h1234; RD2_E = 32'h5678; BranchE = 1; PCE = 32'h200; Imm_Ext_E = 32'h10;
      run_step("unused_op");
    end

    // Jump redirects regardless of the ALU result
    bubble();
    JumpE = 1; RD1_E = 1; RD2_E = 1; PCE = 32'h400; Imm_Ext_E = 32'h20; RegWriteE = 1;
    ResultSrcE = 2'b10; RD_E = 1; PCPlus4E = 32'h404;
    run_step("jump");

    // Store: immediate addressing, data from the B-forward path
    bubble();
    MemWriteE = 1; ALUSrcE = 1; Imm_Ext_E = 4; RD1_E = 32'h1000; RD2_E = 32'hDEAD;
    run_step("store");
    check("store:addr", ALUResultM, 32'h1004);
    check("store:data", WriteDataM, 32'hDEAD);

    // Bubble: no write enables, no count
    bubble();
    run_step("bubble");

    // Randomised mix
    for (int i = 0; i < 24; i++) begin
      RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
      BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
      ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom);
      RD1_E = $urandom_range(0, 3); RD2_E = $urandom_range(0, 3);
      Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom; RD_E = 5'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom_range(0, 3);
      run_step("random");
    end

    // Saturation: preload just below the ceiling, then two taken jumps
    bubble();
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    check("sat:preload", BranchTakenCount, 32'hFFFF_FFFE);
    JumpE = 1;
    run_step("sat_reach");
    check("sat_reach:value", BranchTakenCount, 32'hFFFF_FFFF);
    run_step("sat_hold");
    check("sat_hold:value", BranchTakenCount, 32'hFFFF_FFFF);

    // Load non-zero registers, then reset mid-stream with one in flight
    bubble();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b01; RD_E = 7; RD1_E = 3; RD2_E = 4;
    PCPlus4E = 32'h88;
    run_step("pre_reset");
    RD1_E = 50; RD2_E = 60; RD_E = 9; PCE = 32'h300; Imm_Ext_E = 32'h40;
    #2;
    rst = 1'b0;
    #1;
    check_regs_zero("async_reset");
    check("reset:PCTargetE", PCTargetE, 32'h340);
    JumpE = 1;
    #1;
    check("reset:PCSrcE", PCSrcE, 1);
    @(posedge clk);
    #1;
    check_regs_zero("reset_edge");
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_alu = 0;
    m_cnt = 0;
    JumpE = 0;
    run_step("post_reset");
    check("post_reset:value", ALUResultM, 32'd110);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  input  1 each  ID/EX control bits.
REQ-005 ResultSrcE  input  2  writeback select, carried through unchanged.
REQ-006 ALUControlE  input  3  ALU operation.
REQ-007 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  input  32 each  ID/EX operands and PC values.
REQ-008 RD_E  input  5  destination register.
REQ-009 ForwardAE, ForwardBE  input  2 each  forwarding selects from the hazard unit.
REQ-010 ResultW  input  32  writeback-stage result.
REQ-011 PCSrcE  output  1  redirect fetch (combinational).
REQ-012 PCTargetE  output  32  redirect address (combinational).
REQ-013 RegWriteM, MemWriteM  output  1 each  registered controls.
REQ-014 ResultSrcM  output  2  registered writeback select.
REQ-015 RD_M  output  5  registered destination.
REQ-016 ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered data.
REQ-017 BranchTakenCount  output  32  redirect counter.

Function
REQ-018 SrcAE SHALL select RD1_E for ForwardAE=00, ResultW for 01, ALUResultM for 10, and RD1_E for 11.
REQ-019 The B-forward value SHALL select from RD2_E, ResultW and ALUResultM using the same ForwardBE encoding.
REQ-020 SrcBE SHALL be Imm_Ext_E when ALUSrcE=1, else the B-forward value.
REQ-021 The ALU SHALL decode ALUControlE as: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 32'h1 or 32'h0); 100, 110 and 111 SHALL produce 32'h0.
REQ-022 Add and sub SHALL wrap modulo 2^32, with no overflow output.
REQ-023 ZeroE SHALL be 1 exactly when the ALU result is 32'h0.
REQ-024 PCTargetE SHALL equal PCE + Imm_Ext_E, modulo 2^32.
REQ-025 PCSrcE SHALL equal (BranchE & ZeroE) | JumpE, evaluated in the same cycle.
REQ-026 On each rising clk edge, the EX/MEM registers SHALL capture the following (1-cycle latency, no stall input):
- RegWriteE, MemWriteE, ResultSrcE and RD_E;
- the ALU result into ALUResultM;
- the B-forward value (pre-ALUSrc mux) into WriteDataM;
- PCPlus4E into PCPlus4M.
REQ-027 ALUResultM used for forwarding SHALL be the registered value, so back-to-back dependent operations see the previous cycle's result.
REQ-028 BranchTakenCount SHALL increment by 1 on each rising edge where PCSrcE=1.
REQ-029 BranchTakenCount SHALL saturate at 32'hFFFFFFFF.
REQ-030 An ID/EX bubble (all controls 0) SHALL propagate as RegWriteM=0 and MemWriteM=0, and SHALL NOT increment the counter.

Reset
REQ-031 While rst=0, all registered outputs and BranchTakenCount SHALL be 0, immediately and independent of clk.
REQ-032 An in-flight instruction SHALL be discarded when reset asserts mid-operation.
REQ-033 The first capture SHALL occur on the first rising edge after rst returns to 1.
REQ-034 During reset, PCSrcE and PCTargetE SHALL still follow their inputs combinationally.

Structure
REQ-035 The ALUControl encodings and forward-select encodings SHALL be defined as constants in a shared package used by the control unit and the hazard unit.
REQ-036 The ALU SHALL be a separate sub-module named ALU, with inputs A, B, ALUControl and outputs Result, Zero.

Verification
REQ-037 RD1_E=5, RD2_E=7, ALUControlE=000, ALUSrcE=0, RegWriteE=1, RD_E=3 -> after 1 edge: ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-038 ALUControlE=001, RD1_E=RD2_E=9, BranchE=1, PCE=0x100, Imm_Ext_E=0xFFFFFFF8 -> same cycle: PCSrcE=1, PCTargetE=0xF8; counter +1 after the edge.
REQ-039 Cycle 1: add 2+3 -> ALUResultM=5; cycle 2: ForwardAE=10, ForwardBE=01, ResultW=10, add -> ALUResultM=15.
REQ-040 ALUControlE=101, RD1_E=0xFFFFFFFF, RD2_E=1 -> ALUResultM=1; with operands swapped -> ALUResultM=0.
REQ-041 MemWriteE=1, ALUSrcE=1, Imm_Ext_E=4, RD2_E=0xDEAD -> ALUResultM=RD1_E+4, WriteDataM=0xDEAD, MemWriteM=1.
REQ-042 Assert rst mid-stream with non-zero registers and the counter preloaded to 0xFFFFFFFF via saturation -> all registered outputs go to 0 immediately; separately, a taken branch at the saturated count leaves 0xFFFFFFFF.
